// File: rtl/acorn128_encdec_core.sv
// ACORN-128 message/padding engine: DATA_W unrolled state-update steps per cycle with
// valid/ready data sides. Define ACORN_KS_OUT_EN to add the registered ks_out port.
module acorn128_encdec_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [292:0]      state_in,
  input  logic [LEN_W-1:0]  msg_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
`ifdef ACORN_KS_OUT_EN
  output logic [DATA_W-1:0] ks_out,
`endif
  output logic [292:0]      state_out
);

  typedef enum logic [1:0] {StIdle, StMsg, StPad, StDone} st_e;

  st_e               st_q;
  logic              mode_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  word_cnt_q;
  logic [8:0]        pad_cnt_q;
  logic [292:0]      state_q;
  logic [292:0]      state_out_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              done_q;
`ifdef ACORN_KS_OUT_EN
  logic [DATA_W-1:0] ks_q;
  logic [DATA_W-1:0] chunk_ks;
`endif

  logic [292:0]      chunk_state;
  logic [DATA_W-1:0] chunk_out;
  logic [292:0]      step_s;
  logic              step_ks;
  logic              step_m;
  logic              step_ca;
  logic [8:0]        step_p;
  logic              accept;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // The six LFSR taps are folded in order, so each uses the not-yet-updated lower tap.
  function automatic logic [292:0] lfsr_mix(input logic [292:0] s);
    logic [292:0] r;
    r = s;
    r[289] = r[289] ^ r[235] ^ r[230];
    r[230] = r[230] ^ r[196] ^ r[193];
    r[193] = r[193] ^ r[160] ^ r[154];
    r[154] = r[154] ^ r[111] ^ r[107];
    r[107] = r[107] ^ r[66]  ^ r[61];
    r[61]  = r[61]  ^ r[23]  ^ r[0];
    return r;
  endfunction

  function automatic logic keystream(input logic [292:0] s);
    return s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
  endfunction

  function automatic logic feedback(input logic [292:0] s, input logic ks, input logic ca,
                                    input logic cb);
    return s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ (ca & s[196]) ^ (cb & ks);
  endfunction

  assign in_ready  = (st_q == StMsg) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (st_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign state_out = state_out_q;
`ifdef ACORN_KS_OUT_EN
  assign ks_out    = ks_q;
`endif

  // One cycle's worth of chained steps; in PAD the input word is ignored.
  always_comb begin
    step_s    = state_q;
    step_ks   = 1'b0;
    step_m    = 1'b0;
    step_ca   = 1'b0;
    step_p    = '0;
    chunk_out = '0;
`ifdef ACORN_KS_OUT_EN
    chunk_ks  = '0;
`endif
    for (int k = 0; k < DATA_W; k++) begin
      step_s  = lfsr_mix(step_s);
      step_ks = keystream(step_s);
      step_p  = pad_cnt_q + 9'(k);
      if (st_q == StPad) begin
        step_m  = (step_p == 9'd0);
        step_ca = (step_p < 9'd128);
      end else begin
        step_m  = mode_q ? (in_data[k] ^ step_ks) : in_data[k];
        step_ca = 1'b1;
      end
      chunk_out[k] = in_data[k] ^ step_ks;
`ifdef ACORN_KS_OUT_EN
      chunk_ks[k]  = step_ks;
`endif
      step_s = {feedback(step_s, step_ks, step_ca, 1'b0) ^ step_m, step_s[292:1]};
    end
    chunk_state = step_s;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q        <= StIdle;
      mode_q      <= 1'b0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      pad_cnt_q   <= '0;
      state_q     <= '0;
      state_out_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef ACORN_KS_OUT_EN
      ks_q        <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (out_valid_q && out_ready && !accept) begin
        out_valid_q <= 1'b0;
      end
      unique case (st_q)
        StIdle: begin
          if (start) begin
            mode_q     <= mode;
            state_q    <= state_in;
            len_q      <= msg_words;
            word_cnt_q <= '0;
            pad_cnt_q  <= '0;
            st_q       <= (msg_words == '0) ? StPad : StMsg;
          end
        end
        StMsg: begin
          if (accept) begin
            state_q     <= chunk_state;
            out_data_q  <= chunk_out;
            out_valid_q <= 1'b1;
`ifdef ACORN_KS_OUT_EN
            ks_q        <= chunk_ks;
`endif
            word_cnt_q  <= word_cnt_q + LEN_W'(1);
            if (word_cnt_q == len_q - LEN_W'(1)) begin
              st_q <= StPad;
            end
          end
        end
        StPad: begin
          state_q   <= chunk_state;
          pad_cnt_q <= pad_cnt_q + 9'(DATA_W);
          if (pad_cnt_q == 9'(256 - DATA_W)) begin
            st_q <= StDone;
          end
        end
        StDone: begin
          // Hand over only once the last output word has drained.
          if (!out_valid_q) begin
            state_out_q <= state_q;
            done_q      <= 1'b1;
            st_q        <= StIdle;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_acorn128_encdec_core.sv
// Bench for acorn128_encdec_core: bit-serial queue-based ACORN model plus per-cycle scoreboard
// on three instances (DATA_W = 8, 1 and 32).
module tb_acorn128_encdec_core;

  localparam int unsigned LW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DATA_W = 8 instance
  logic          start8, mode8, in_valid8, out_ready8, in_ready8, out_valid8, busy8, done8;
  logic [292:0]  state_in8, state_out8;
  logic [LW-1:0] words8;
  logic [7:0]    in_data8, out_data8;
  // DATA_W = 1 instance
  logic          start1, mode1, in_valid1, out_ready1, in_ready1, out_valid1, busy1, done1;
  logic [292:0]  state_in1, state_out1;
  logic [LW-1:0] words1;
  logic [0:0]    in_data1, out_data1;
  // DATA_W = 32 instance
  logic          start32, mode32, in_valid32, out_ready32, in_ready32, out_valid32, busy32, done32;
  logic [292:0]  state_in32, state_out32;
  logic [LW-1:0] words32;
  logic [31:0]   in_data32, out_data32;
`ifdef ACORN_KS_OUT_EN
  logic [7:0]    ks8;
  logic [0:0]    ks1;
  logic [31:0]   ks32;
`endif

  acorn128_encdec_core #(.DATA_W(8), .LEN_W(LW)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .state_in(state_in8),
    .msg_words(words8), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .busy(busy8),
`ifdef ACORN_KS_OUT_EN
    .ks_out(ks8),
`endif
    .done(done8), .state_out(state_out8)
  );

  acorn128_encdec_core #(.DATA_W(1), .LEN_W(LW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .state_in(state_in1),
    .msg_words(words1), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .busy(busy1),
`ifdef ACORN_KS_OUT_EN
    .ks_out(ks1),
`endif
    .done(done1), .state_out(state_out1)
  );

  acorn128_encdec_core #(.DATA_W(32), .LEN_W(LW)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .mode(mode32), .state_in(state_in32),
    .msg_words(words32), .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32), .busy(busy32),
`ifdef ACORN_KS_OUT_EN
    .ks_out(ks32),
`endif
    .done(done32), .state_out(state_out32)
  );

  logic [31:0]  exp8_q[$], exp1_q[$], exp32_q[$];
  logic [292:0] exp_st8, exp_st1, exp_st32;
  int           done_cnt8 = 0;

  task automatic chk(input string name, input logic [292:0] act, input logic [292:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] act, input int have,
                          input logic [31:0] exp);
    checks++;
    if (have == 0) begin
      errors++;
      $display("FAIL %s: unexpected word %0h, none outstanding", name, act);
    end else if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic bit maj3(input bit a, input bit b, input bit c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Bit-serial reference: the state is a queue, S[0] at the front; each step pops S[0] and
  // appends the feedback bit. nbits message steps, then 256 padding steps.
  task automatic model_run(input logic [292:0] s0, input bit dec, input int nbits,
                           input logic [1023:0] din, output logic [1023:0] dout,
                           output logic [292:0] sfin);
    bit s[$];
    bit ks, m, ca, f;
    s = {};
    for (int i = 0; i < 293; i++) s.push_back(s0[i]);
    dout = '0;
    for (int j = 0; j < nbits + 256; j++) begin
      s[289] = s[289] ^ s[235] ^ s[230];
      s[230] = s[230] ^ s[196] ^ s[193];
      s[193] = s[193] ^ s[160] ^ s[154];
      s[154] = s[154] ^ s[111] ^ s[107];
      s[107] = s[107] ^ s[66] ^ s[61];
      s[61]  = s[61] ^ s[23] ^ s[0];
      ks = s[12] ^ s[154] ^ maj3(s[235], s[61], s[193]) ^ (s[230] ? s[111] : s[66]);
      if (j < nbits) begin
        dout[j] = din[j] ^ ks;
        m  = dec ? dout[j] : din[j];
        ca = 1'b1;
      end else begin
        m  = (j == nbits);
        ca = (j - nbits) < 128;
      end
      f = s[0] ^ !s[107] ^ maj3(s[244], s[23], s[160]) ^ (ca & s[196]) ^ m;
      void'(s.pop_front());
      s.push_back(f);
    end
    for (int i = 0; i < 293; i++) sfin[i] = s[i];
  endtask

  function automatic logic [292:0] rnd_state();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r[292:0];
  endfunction

  // Scoreboard: every transferred output word and every done pulse is checked.
  always @(negedge clk) begin
    int n;
    logic [31:0] w;
    #2;
    if (rst) begin
      if (out_valid8 && out_ready8) begin
        n = exp8_q.size();
        w = (n > 0) ? exp8_q.pop_front() : 32'h0;
        chk_word("out8", 32'(out_data8), n, w);
      end
      if (out_valid1 && out_ready1) begin
        n = exp1_q.size();
        w = (n > 0) ? exp1_q.pop_front() : 32'h0;
        chk_word("out1", 32'(out_data1), n, w);
      end
      if (out_valid32 && out_ready32) begin
        n = exp32_q.size();
        w = (n > 0) ? exp32_q.pop_front() : 32'h0;
        chk_word("out32", out_data32, n, w);
      end
      if (done8) begin
        done_cnt8++;
        chk("state_out8", state_out8, exp_st8);
      end
      if (done1)  chk("state_out1", state_out1, exp_st1);
      if (done32) chk("state_out32", state_out32, exp_st32);
    end
  end

  task automatic run8(input string tag, input logic [292:0] s0, input bit md, input int n,
                      input logic [1023:0] din, input int stall, input int restart_at,
                      output logic [1023:0] dout, output logic [292:0] sf);
    int idx, lat, st_edge, stall_left;
    bit seen_first, got_done, ir_seen;
    model_run(s0, md, n * 8, din, dout, sf);
    for (int i = 0; i < n; i++) exp8_q.push_back(32'(dout[i*8 +: 8]));
    exp_st8 = sf;
    @(negedge clk);
    start8 = 1'b1; mode8 = md; state_in8 = s0; words8 = LW'(n);
    st_edge = cyc + 1;
    @(negedge clk);
    start8 = 1'b0; mode8 = ~md; state_in8 = rnd_state(); words8 = LW'($urandom);
    idx = 0; lat = 0; stall_left = stall; seen_first = 0; got_done = 0; ir_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done8) begin
        got_done = 1;
        lat = cyc - st_edge;
        break;
      end
      if (out_valid8) seen_first = 1;
      if (seen_first && stall_left > 0) begin
        out_ready8 = 1'b0;
        stall_left--;
      end else begin
        out_ready8 = 1'b1;
      end
      start8    = (c == restart_at);
      in_valid8 = (idx < n);
      in_data8  = in_valid8 ? din[idx*8 +: 8] : 8'($urandom);
      #1;
      ir_seen = ir_seen | in_ready8;
      if (!out_ready8) chk({tag, "_stall_in_ready"}, 293'(in_ready8), 293'(0));
      if (in_valid8 && in_ready8) idx++;
      @(negedge clk);
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1; start8 = 1'b0;
    chk({tag, "_done_seen"}, 293'(got_done), 293'(1));
    chk({tag, "_latency"}, 293'(lat), 293'(n + 33 + stall));
    chk({tag, "_words_taken"}, 293'(idx), 293'(n));
    chk({tag, "_words_left"}, 293'(exp8_q.size()), 293'(0));
    if (n == 0) chk({tag, "_no_in_ready"}, 293'(ir_seen), 293'(0));
    @(negedge clk);
    chk({tag, "_idle"}, 293'(busy8), 293'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [292:0]  s0, sfe, sfd, sf;
    logic [1023:0] pt, ct, pt2, dummy, wpt;
    int idx1, idx32, lat1, lat32, st_edge, dsnap;

    rst = 1'b0;
    start8 = 0; mode8 = 0; in_valid8 = 0; out_ready8 = 1; state_in8 = '0; words8 = '0;
    in_data8 = '0;
    start1 = 0; mode1 = 0; in_valid1 = 0; out_ready1 = 1; state_in1 = '0; words1 = '0;
    in_data1 = '0;
    start32 = 0; mode32 = 0; in_valid32 = 0; out_ready32 = 1; state_in32 = '0; words32 = '0;
    in_data32 = '0;
    exp_st8 = '0; exp_st1 = '0; exp_st32 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("rst_busy", 293'({busy8, busy1, busy32}), 293'(0));
    chk("rst_in_ready", 293'({in_ready8, in_ready1, in_ready32}), 293'(0));
    chk("rst_out_valid", 293'({out_valid8, out_valid1, out_valid32}), 293'(0));
    chk("rst_done", 293'({done8, done1, done32}), 293'(0));
    chk("rst_out_data", 293'({out_data8, out_data1, out_data32}), 293'(0));
    chk("rst_state_out", state_out8 | state_out1 | state_out32, 293'(0));

    // Length 0 from the zero state: padding only, done 33 edges after start.
    run8("len0", '0, 0, 0, '0, 0, -1, dummy, sf);

    // From the zero state no keystream tap is nonzero for the first 100 steps.
    pt = '0;
    pt[63:0] = 64'hA5C3_0FF0_1234_9ABC;
    run8("zero8", '0, 0, 8, pt, 0, -1, ct, sf);
    chk("pin_zero_ks", ct[63:0], pt[63:0]);

    // Round trip with random state and plaintext.
    s0 = rnd_state();
    pt = '0;
    for (int i = 0; i < 4; i++) pt[i*32 +: 32] = $urandom;
    run8("enc", s0, 0, 16, pt, 0, -1, ct, sfe);
    run8("dec", s0, 1, 16, ct, 0, -1, pt2, sfd);
    chk("rt_plain", pt2[127:0], pt[127:0]);
    chk("rt_state", sfd, sfe);

    // Backpressure after the first word.
    s0 = rnd_state();
    pt = '0;
    for (int i = 0; i < 2; i++) pt[i*32 +: 32] = $urandom;
    run8("bp", s0, 0, 8, pt, 5, -1, ct, sf);

    // Second start pulse in MSG must be ignored.
    s0 = rnd_state();
    pt = '0;
    for (int i = 0; i < 4; i++) pt[i*32 +: 32] = $urandom;
    run8("restart", s0, 1, 16, pt, 0, 3, ct, sf);

    // Width equivalence: DATA_W = 1 and 32 on the same 128-bit message.
    wpt = '0;
    wpt[127:0] = 128'h00112233445566778899AABBCCDDEEFF;
    s0 = rnd_state();
    model_run(s0, 0, 128, wpt, ct, sf);
    for (int i = 0; i < 128; i++) exp1_q.push_back(32'(ct[i]));
    for (int i = 0; i < 4; i++) exp32_q.push_back(ct[i*32 +: 32]);
    exp_st1 = sf; exp_st32 = sf;
    @(negedge clk);
    start1 = 1; start32 = 1; mode1 = 0; mode32 = 0; state_in1 = s0; state_in32 = s0;
    words1 = LW'(128); words32 = LW'(4);
    st_edge = cyc + 1;
    @(negedge clk);
    start1 = 0; start32 = 0; state_in1 = '0; state_in32 = '0; words1 = '0; words32 = '0;
    idx1 = 0; idx32 = 0; lat1 = -1; lat32 = -1;
    for (int c = 0; c < 1000; c++) begin
      if (done1 && lat1 < 0) lat1 = cyc - st_edge;
      if (done32 && lat32 < 0) lat32 = cyc - st_edge;
      if (lat1 >= 0 && lat32 >= 0) break;
      in_valid1  = (idx1 < 128);
      in_data1   = in_valid1 ? wpt[idx1] : 1'b0;
      in_valid32 = (idx32 < 4);
      in_data32  = in_valid32 ? wpt[idx32*32 +: 32] : 32'h0;
      #1;
      if (in_valid1 && in_ready1) idx1++;
      if (in_valid32 && in_ready32) idx32++;
      @(negedge clk);
    end
    in_valid1 = 0; in_valid32 = 0;
    chk("w1_latency", 293'(lat1), 293'(385));
    chk("w32_latency", 293'(lat32), 293'(13));
    chk("w_words_left", 293'(exp1_q.size() + exp32_q.size()), 293'(0));

    // Reset in PAD cycle 10 of a length-0 run.
    exp_st8 = '0;
    @(negedge clk);
    start8 = 1; words8 = '0; state_in8 = rnd_state();
    @(negedge clk);
    start8 = 0;
    repeat (9) @(negedge clk);
    dsnap = done_cnt8;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_busy", 293'(busy8), 293'(0));
    chk("mid_rst_out_valid", 293'(out_valid8), 293'(0));
    chk("mid_rst_out_data", 293'(out_data8), 293'(0));
    chk("mid_rst_state_out", state_out8, 293'(0));
    repeat (40) @(negedge clk);
    chk("mid_rst_no_done", 293'(done_cnt8), 293'(dsnap));
    s0 = rnd_state();
    pt = '0;
    pt[63:0] = {$urandom, $urandom};
    run8("post_rst", s0, 0, 8, pt, 0, -1, ct, sf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acorn128_encdec_core.md
Name: acorn128_encdec_core

Overview:
- Parametrised ACORN-128 message-phase engine; successor to the bit-serial encryption block.
- Takes the 293-bit state after key/IV/AD processing and streams message words in, applying DATA_W state-update steps per cycle.
- Supports encrypt and decrypt modes, then performs the 256-step padding phase (1, then 255 zeros) and presents the final state to the tag/finalisation block.
- Valid/ready handshakes on both data sides replace the start-level-driven counter scheme.

Parameters:
- DATA_W, 8, message bits per word = ACORN steps unrolled per cycle; legal values 1, 8, 16, 32 (256 % DATA_W == 0).
- LEN_W, 16, width of the message word count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = encrypt, 1 = decrypt; latched at start
- state_in  in  293  ACORN state at message-phase entry; latched at start
- msg_words  in  LEN_W  message length in words; latched at start
- in_valid  in  1  input word valid
- in_ready  out  1  core accepts input word
- in_data  in  DATA_W  plaintext (enc) or ciphertext (dec); bit 0 is processed first
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts output word
- out_data  out  DATA_W  ciphertext (enc) or plaintext (dec); bit-aligned with in_data
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when state_out is final
- state_out  out  293  state after the padding phase; held until the next start

Behaviour:
- Reset (rst == 0 at posedge clk) forces FSM = IDLE and clears all of the following: state register, counters, in_ready, out_valid, out_data, busy, done, state_out. Reset mid-operation abandons the message; no done pulse is produced.
- Per step j, with state S:
  - ks = ACORN-128 keystream function of S.
  - m is the message bit: enc m = in bit, out bit = m ^ ks; dec out bit = in bit ^ ks, m = out bit.
  - S = ACORN-128 state update with (m, ca, cb).
  - DATA_W steps are chained combinationally within one cycle, bit k using the state after steps 0..k-1.
- Message steps use ca = 1, cb = 0.
- Padding steps use pad index p = 0..255: m = (p == 0); ca = (p < 128); cb = 0.
- FSM:
  - IDLE: on start, latch mode, state_in and msg_words; clear word_cnt. Go to PAD if msg_words == 0, else go to MSG.
  - MSG: in_ready = !out_valid || out_ready. On in_valid && in_ready: advance DATA_W steps, register out_data, set out_valid = 1, word_cnt++. After word msg_words-1 is accepted, go to PAD.
  - PAD: one DATA_W-step chunk per cycle, pad_cnt += DATA_W, no handshake. When pad_cnt reaches 256, go to DONE.
  - DONE: wait for out_valid == 0. Then, in one cycle, copy the state to state_out, pulse done, and return to IDLE.
- out_valid clears on out_ready when no new word is accepted in the same cycle. Simultaneous accept-in and drain-out in MSG keeps out_valid = 1 with the new data.
- in_ready is 0 outside MSG.
- start is ignored while busy.
- msg_words wrap is not supported: the maximum is 2^LEN_W - 1.
- Latency with no stalls and start sampled at edge k: done is high in the cycle after edge k + msg_words + 256/DATA_W + 1.

Optional Feature:
- Macro ACORN_KS_OUT_EN.
- Defined: adds output port ks_out [DATA_W-1:0], registered alongside out_data and qualified by out_valid. It carries the keystream bits used for that word.
- Undefined: no ks_out port and no keystream register.
- Core behaviour is otherwise identical in both builds.

Test Plan:
- Length 0: DATA_W=8, msg_words=0, state_in=0, start at cycle 0 → no in_ready, done at cycle 34. state_out equals a 256-step bit-serial golden model run from the zero state.
- Round trip: DATA_W=8, msg_words=16, random state_in and plaintext, encrypt then decrypt with the same state_in → decrypted bytes equal the plaintext; state_out identical in both runs.
- Width equivalence: same 128-bit plaintext (0x00112233445566778899AABBCCDDEEFF), DATA_W=1 and DATA_W=32 → identical ciphertext bits and state_out. Done at cycles 385 and 13 respectively (msg_words 128 and 4).
- Backpressure: DATA_W=8, msg_words=8, out_ready low for 5 cycles after the first word → in_ready low during the stall, no word lost or duplicated, done delayed 5 cycles, ciphertext matches the golden model.
- Reset mid-op: rst=0 during PAD cycle 10 → next cycle busy=0, out_valid=0, state_out=0, no done. A new start runs a clean message.
- Ignored start: a second start pulse during MSG → no effect, and the latched msg_words and mode are unchanged.
